mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS datapath's MULT/MULTU/DIV/DIVU instructions.
- Accepts two operands on Start and computes over width+1 cycles.
- Presents a 2*width result split into Hi/Lo, with a one-cycle Done pulse.
- Done drives the Enable of the HI and LO Register instances directly downstream; Hi/Lo drive their Data inputs.

---
 rtl/mult_div_unit_pkg.sv | 26 ++
 rtl/mdu_negate.sv | 12 +
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states
// and small opcode classification helpers.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ITER = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: y = en ? -x : x.
module mdu_negate #(
  parameter int width = 32
) (
  input  logic             en_i,
  input  logic [width-1:0] x_i,
  output logic [width-1:0] y_o
);

  assign y_o = en_i ? (~x_i + width'(1)) : x_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one radix-2 step per cycle, sign fix-up at the end.
// Optional DivZero output enabled by defining MDU_DIVZERO_FLAG_EN.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  output logic             Busy,
  output logic             Done,
`ifdef MDU_DIVZERO_FLAG_EN
  output logic             DivZero,
`endif
  output logic [width-1:0] Hi,
  output logic [width-1:0] Lo
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;

  state_e             state_q, state_d;
  op_e                op_q;
  logic               sign_a_q, sign_b_q, divz_q;
  logic [CW-1:0]      cnt_q;
  logic [width-1:0]   opnd_q;
  logic [width-1:0]   acc_hi_q, acc_lo_q;
  logic [width-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               dz_q;

  // Decode of the incoming request, used only at the accepting edge
  op_e                op_in;
  logic               in_signed, in_div, in_divz, accept;
  logic [width-1:0]   abs_a, abs_b;

  assign op_in     = op_e'(Op);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign in_divz   = in_div && (B == '0);
  assign accept    = (state_q == S_IDLE) && Start;

  // A divide by zero keeps the raw dividend so the remainder comes out equal to A
  mdu_negate #(.width(width)) u_abs_a (
    .en_i (in_signed && A[width-1] && !in_divz),
    .x_i  (A),
    .y_o  (abs_a)
  );

  mdu_negate #(.width(width)) u_abs_b (
    .en_i (in_signed && B[width-1]),
    .x_i  (B),
    .y_o  (abs_b)
  );

  // One iteration step for each operation class
  logic [width:0]     mul_sum;
  logic [width:0]     div_shift, div_diff;
  logic               div_ok;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[width-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ok    = !div_diff[width];

  // Result sign correction
  logic               cur_signed, cur_div;
  logic [2*width-1:0] prod_fix;
  logic [width-1:0]   quo_fix, rem_fix;

  assign cur_signed = op_is_signed(op_q);
  assign cur_div    = op_is_div(op_q);

  mdu_negate #(.width(2*width)) u_fix_prod (
    .en_i (!cur_div && cur_signed && (sign_a_q ^ sign_b_q)),
    .x_i  ({acc_hi_q, acc_lo_q}),
    .y_o  (prod_fix)
  );

  mdu_negate #(.width(width)) u_fix_quo (
    .en_i (cur_div && cur_signed && !divz_q && (sign_a_q ^ sign_b_q)),
    .x_i  (acc_lo_q),
    .y_o  (quo_fix)
  );

  mdu_negate #(.width(width)) u_fix_rem (
    .en_i (cur_div && cur_signed && !divz_q && sign_a_q),
    .x_i  (acc_hi_q),
    .y_o  (rem_fix)
  );

  // FSM: state register
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_ITER;
      S_ITER:  if (cnt_q == CW'(width-1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    Busy = (state_q != S_IDLE);
    Done = done_q;
  end

  // Datapath
  always_ff @(posedge Clock) begin
    if (Reset) begin
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      divz_q   <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= (state_q == S_FIX);
      dz_q   <= (state_q == S_FIX) && divz_q;
      if (accept) begin
        op_q     <= op_in;
        sign_a_q <= A[width-1];
        sign_b_q <= B[width-1];
        divz_q   <= in_divz;
        cnt_q    <= '0;
        opnd_q   <= in_div ? abs_b : abs_a;
        acc_hi_q <= '0;
        acc_lo_q <= in_div ? abs_a : abs_b;
      end else if (state_q == S_ITER) begin
        cnt_q <= cnt_q + CW'(1);
        if (cur_div) begin
          acc_hi_q <= div_ok ? div_diff[width-1:0] : div_shift[width-1:0];
          acc_lo_q <= {acc_lo_q[width-2:0], div_ok};
        end else begin
          acc_hi_q <= mul_sum[width:1];
          acc_lo_q <= {mul_sum[0], acc_lo_q[width-1:1]};
        end
      end else if (state_q == S_FIX) begin
        hi_q <= cur_div ? rem_fix : prod_fix[2*width-1:width];
        lo_q <= cur_div ? quo_fix : prod_fix[width-1:0];
      end
    end
  end

  assign Hi = hi_q;
  assign Lo = lo_q;
`ifdef MDU_DIVZERO_FLAG_EN
  assign DivZero = dz_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit (width=32), plus hand-written
// sequences for back-to-back issue, ignored Start during ITER and mid-op reset.
module tb_mult_div_unit;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         srst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    logic         div_zero;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] hold_hi = '0;
    logic [W-1:0] hold_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.width(W)) dut (
        .Clock   (clk),
        .Reset   (srst),
        .Start   (start),
        .Op      (op),
        .A       (a),
        .B       (b),
        .Busy    (busy),
        .Done    (done),
`ifdef MDU_DIVZERO_FLAG_EN
        .DivZero (div_zero),
`endif
        .Hi      (hi),
        .Lo      (lo)
    );

`ifndef MDU_DIVZERO_FLAG_EN
    assign div_zero = 1'b0;
`endif

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic         exp_dz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drive a request for one edge, then scramble inputs to prove they are not resampled
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = ~o;
        a = ~x;
        b = ~y;
    endtask

    task automatic wait_done(input string name, input logic [W-1:0] eh, input logic [W-1:0] el,
                             input logic edz, input bit noise);
        int done_k = 0;
        bit prof_ok = 1'b1;
        for (int k = 1; k <= LAT + 8; k++) begin
            if (noise) begin
                start = (k >= 2 && k <= 12) ? k[0] : 1'b0;
                op = 2'($urandom);
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk);
            #1;
            if (done) begin
                done_k = k;
                break;
            end
            if (!busy || hi !== hold_hi || lo !== hold_lo || div_zero)
                prof_ok = 1'b0;
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(done_k), 64'(LAT));
        check({name, "_iter_profile"}, 64'(prof_ok), 64'd1);
        check({name, "_hi"}, 64'(hi), 64'(eh));
        check({name, "_lo"}, 64'(lo), 64'(el));
        check({name, "_busy_at_done"}, 64'(busy), 64'd0);
`ifdef MDU_DIVZERO_FLAG_EN
        check({name, "_divzero"}, 64'(div_zero), 64'(edz));
`endif
        $display("op=%0d %s hi=0x%08h lo=0x%08h dz=%0b done_cycle=%0d", op, name, hi, lo, div_zero, done_k);
        hold_hi = eh;
        hold_lo = el;
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit ok = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (done || busy || div_zero) ok = 1'b0;
        end
        check(name, 64'(ok), 64'd1);
    endtask

    initial begin
        vecs[0]  = '{"mult_neg3x7",    2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{"multu_max",      2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{"divu_100_7",     2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[3]  = '{"div_neg7_2",     2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{"div_min_neg1",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{"divu_5_0",       2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{"div_neg7_0",     2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{"mult_min_min",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8]  = '{"div_7_neg2",     2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{"multu_3x4",      2'b01, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0};
        vecs[10] = '{"mult_x_neg1",    2'b00, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0};
        vecs[11] = '{"divu_max_10",    2'b11, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 1'b0};

        srst = 1'b1;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_divzero", 64'(div_zero), 64'd0);
        @(posedge clk);
        #1;

        // Table vectors are issued back-to-back, each in the previous Done cycle
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz, 1'b0);
        end
        expect_quiet("idle_after_table", 4);

        // Start toggled with fresh operands during ITER must be ignored
        issue(2'b00, 32'hFFFFFFFD, 32'd7);
        wait_done("mult_noise", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b1);
        expect_quiet("single_done_after_noise", LAT + 5);

        // Reset after iteration 10 of a DIV discards the operation
        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        repeat (10) @(posedge clk);
        #1;
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_hi", 64'(hi), 64'd0);
        check("midreset_lo", 64'(lo), 64'd0);
        $display("mid-op reset busy=%0b done=%0b hi=0x%08h lo=0x%08h", busy, done, hi, lo);
        hold_hi = '0;
        hold_lo = '0;
        expect_quiet("no_done_after_reset", LAT + 5);
        issue(2'b01, 32'd3, 32'd4);
        wait_done("multu_after_reset", 32'd0, 32'd12, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
